// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// State encoding, op-select constants and default width.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder from two half-adders.
// The two partial carries are mutually exclusive, so an OR merges them.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (w_s0),
    .c (w_c0)
  );

  halfadder u_ha1 (
    .a (w_s0),
    .b (cin),
    .s (s),
    .c (w_c1)
  );

  assign cout = w_c0 | w_c1;

endmodule

// File: rtl/halfadder.sv
// Half-adder cell: sum and carry of two bits.
// Building block for the full-adder used by the serial datapath.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB-first, one full-adder per cycle.
// Subtraction is a + ~b + 1, with the +1 preloaded as the carry.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic w_sum;
  logic w_cout;

  fa_cell u_fa (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // Control FSM and serial datapath with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opa       <= a;
            r_opb       <= (sub == OP_SUB) ? ~b : b;
            r_carry     <= sub;
            r_count     <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_carry  <= w_cout;
          r_opa    <= r_opa >> 1;
          r_opb    <= r_opb >> 1;
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_count  <= r_count + 1'b1;
          if (r_count == LAST) begin
            // r_carry is the carry into the MSB here
            r_overflow  <= r_carry ^ w_cout;
            r_carry_out <= w_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8.
// Inputs change on falling edges, outputs sampled #1 after rising edges.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       overflow;
  logic       busy;

  int total;
  int bad;

  serial_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 8);
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] ai,
                        input logic [7:0] bi,
                        input logic si,
                        input logic [7:0] er,
                        input logic ec,
                        input logic eo);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    a = ai; b = bi; sub = si;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag, n);
    chk({tag, "_res"}, result, er);
    chk({tag, "_co"}, carry_out, ec);
    chk({tag, "_ov"}, overflow, eo);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld0"}, out_valid, 0);
    chk({tag, "_rdy1"}, in_ready, 1);
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; sub = 1'b0;

    // 1: reset, in_valid held during reset must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_res", result, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_co", carry_out, 0);
    chk("rst_ov", overflow, 0);

    // 2-4: add / subtract vectors
    run_op("add1", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op("add2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add3", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub1", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // 5: backpressure in DONE, then back-to-back attempt
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp", n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'(i * 37); b = ~8'(i * 11); sub = i[0];
      in_valid = ~i[0];
      @(posedge clk); #1;
      chk("bp_res", result, 8'h46);
      chk("bp_co", carry_out, 0);
      chk("bp_ov", overflow, 0);
      chk("bp_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
    end
    @(negedge clk);
    a = 8'h10; b = 8'h01; sub = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_ovld", out_valid, 0);
    chk("b2b_idle", busy, 0);
    chk("b2b_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_acc", busy, 1);
    wait_done("b2b", n);
    chk("b2b_res", result, 8'h0F);
    chk("b2b_co", carry_out, 1);
    chk("b2b_ov", overflow, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // 6: reset pulse mid-shift, then clean op
    @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_res", result, 8'h00);
    chk("mrst_ovld", out_valid, 0);
    run_op("fresh", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
